mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit for the EX stage.
- Replaces the separate fixed-32-bit mul/div instances with one shared datapath: shift-add multiply and restoring divide, signed/unsigned.
- One result per operation; stall request to the pipeline controller; annul input for flush.
- The pipeline keeps a request asserted until done, then consumes {result_hi, result_lo}, i.e. the HI and LO values.

---
 rtl/mdu_iter_if.sv | 32 +++
 rtl/mdu_iter.sv | 161 ++++++++++++++++
 tb/tb_mdu_iter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/response bundle between the EX-stage pipeline and
// the iterative multiply/divide unit.
//   master (pipeline): drives start, op_div, op_signed, annul, opa, opb;
//                      receives busy, stallreq, done, div_by_zero,
//                      result_hi, result_lo.
//   slave  (mdu_iter): the mirror image.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_div;
    logic             op_signed;
    logic             annul;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             stallreq;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    modport master (
        output start, op_div, op_signed, annul, opa, opb,
        input  busy, stallreq, done, div_by_zero, result_hi, result_lo
    );

    modport slave (
        input  start, op_div, op_signed, annul, opa, opb,
        output busy, stallreq, done, div_by_zero, result_hi, result_lo
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: shared iterative multiply / divide unit for the EX stage.
// Shift-add multiply (LSB of multiplier first) and restoring divide
// (one quotient bit per cycle, MSB first) on operand magnitudes, with
// sign correction applied when the result is registered.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus (slave)   start/op_div/op_signed/annul/opa/opb in;
//                 busy/stallreq/done/div_by_zero/result_hi/result_lo out
//   result_hi/lo  multiply: product high/low; divide: remainder/quotient
module mdu_iter #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, remaining dividend / quotient bits}.
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opd_r;      // multiplicand magnitude or divisor magnitude
    logic               is_div_r;
    logic               neg_lo_r;   // negate product / quotient
    logic               neg_hi_r;   // negate remainder
    logic [WIDTH-1:0]   res_hi_r, res_lo_r;
    logic               dbz_r, done_r, busy_r;

    logic               sa_s, sb_s, accept_s, last_s, dz_s, finish_s, q_bit_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s, rem_new_s, res_hi_s, res_lo_s;
    logic [WIDTH:0]     mul_sum_s, rem_sh_s;
    logic [2*WIDTH-1:0] mul_next_s, div_next_s, step_s, prod_s;

    assign sa_s     = bus.op_signed & bus.opa[WIDTH-1];
    assign sb_s     = bus.op_signed & bus.opb[WIDTH-1];
    assign a_mag_s  = sa_s ? -bus.opa : bus.opa;
    assign b_mag_s  = sb_s ? -bus.opb : bus.opb;
    assign accept_s = (state_r == ST_IDLE) & bus.start & ~bus.annul;
    assign last_s   = (cnt_r == CNT_W'(WIDTH - 1));
    assign dz_s     = is_div_r & (opd_r == {WIDTH{1'b0}});
    assign finish_s = (state_r == ST_CALC) & ~bus.annul & (dz_s | last_s);

    // Multiply step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                      + (acc_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

    // Divide step: the shifted remainder needs WIDTH+1 bits before the compare.
    assign rem_sh_s   = acc_r[2*WIDTH-1:WIDTH-1];
    assign q_bit_s    = (rem_sh_s >= {1'b0, opd_r});
    assign rem_new_s  = WIDTH'(rem_sh_s - {1'b0, opd_r});
    assign div_next_s = {(q_bit_s ? rem_new_s : rem_sh_s[WIDTH-1:0]),
                         acc_r[WIDTH-2:0], q_bit_s};

    assign step_s = is_div_r ? div_next_s : mul_next_s;
    assign prod_s = neg_lo_r ? -step_s : step_s;

    // Final result selection; the last iteration and sign correction share one edge.
    always_comb begin
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
        if (dz_s) begin
            // Re-negating the dividend magnitude restores opa as presented.
            res_hi_s = neg_hi_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
            res_lo_s = {WIDTH{1'b1}};
        end else if (is_div_r) begin
            res_hi_s = neg_hi_r ? -step_s[2*WIDTH-1:WIDTH] : step_s[2*WIDTH-1:WIDTH];
            res_lo_s = neg_lo_r ? -step_s[WIDTH-1:0] : step_s[WIDTH-1:0];
        end else begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; annul has priority over completion.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_CALC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (bus.annul) begin
                    state_s = ST_IDLE;
                end else if (dz_s | last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            opd_r    <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            res_hi_r <= {WIDTH{1'b0}};
            res_lo_r <= {WIDTH{1'b0}};
            dbz_r    <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE);
            if (accept_s) begin
                is_div_r <= bus.op_div;
                neg_lo_r <= sa_s ^ sb_s;
                neg_hi_r <= bus.op_div ? sa_s : (sa_s ^ sb_s);
                opd_r    <= bus.op_div ? b_mag_s : a_mag_s;
                acc_r    <= {{WIDTH{1'b0}}, (bus.op_div ? a_mag_s : b_mag_s)};
                cnt_r    <= {CNT_W{1'b0}};
            end else if ((state_r == ST_CALC) && !bus.annul) begin
                acc_r <= step_s;
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (finish_s) begin
                res_hi_r <= res_hi_s;
                res_lo_r <= res_lo_s;
                dbz_r    <= dz_s;
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r & ~bus.annul;
    assign bus.stallreq    = accept_s | (state_r == ST_CALC);
    assign bus.div_by_zero = dbz_r;
    assign bus.result_hi   = res_hi_r;
    assign bus.result_lo   = res_lo_r;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed + scoreboard bench for mdu_iter at WIDTH=32 and WIDTH=8.
module tb_mdu_iter;

    typedef struct packed {
        logic        dbz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    exp_t sb32[$];
    exp_t sb8[$];

    mdu_iter_if #(.WIDTH(32)) b32();
    mdu_iter_if #(.WIDTH(8))  b8();

    mdu_iter #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
    mdu_iter #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        assert (got === want) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Independent reference using the simulator's own wide arithmetic.
    function automatic exp_t model32(input bit dv, input bit sg, input logic [31:0] a,
                                     input logic [31:0] b);
        exp_t   e;
        longint pa, pb, p, q, r;
        pa = sg ? longint'($signed(a)) : longint'({32'd0, a});
        pb = sg ? longint'($signed(b)) : longint'({32'd0, b});
        e.dbz = 1'b0;
        if (!dv) begin
            p    = pa * pb;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.dbz = 1'b1;
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
        end else begin
            q    = pa / pb;
            r    = pa % pb;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        return e;
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic start32(input bit dv, input bit sg, input logic [31:0] a, input logic [31:0] b);
        b32.op_div    = dv;
        b32.op_signed = sg;
        b32.opa       = a;
        b32.opb       = b;
        b32.start     = 1'b1;
    endtask

    task automatic start8(input bit dv, input bit sg, input logic [7:0] a, input logic [7:0] b);
        b8.op_div    = dv;
        b8.op_signed = sg;
        b8.opa       = a;
        b8.opb       = b;
        b8.start     = 1'b1;
    endtask

    // Waits for done (first sample is in the current/accept cycle), checks
    // latency, stall window and pops the scoreboard.
    task automatic wait_done32(input int exp_lat, input bit keep_start);
        int   lat;
        int   stalls;
        exp_t e;
        lat    = -1;
        stalls = 0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (b32.done) begin
                lat = c;
                break;
            end
            if (b32.stallreq) stalls++;
        end
        if (!keep_start) b32.start = 1'b0;
        chk("lat32", lat, exp_lat);
        if (lat >= 0) begin
            chk("stall32_cycles", stalls, exp_lat);
            chk("stall32_in_done", b32.stallreq, 1'b0);
            chk("busy32_in_done", b32.busy, 1'b1);
            chk("sb32_pending", sb32.size() > 0, 1'b1);
            if (sb32.size() > 0) begin
                e = sb32.pop_front();
                chk("hi32", b32.result_hi, e.hi);
                chk("lo32", b32.result_lo, e.lo);
                chk("dbz32", b32.div_by_zero, e.dbz);
            end
        end
    endtask

    task automatic wait_done8(input int exp_lat);
        int   lat;
        exp_t e;
        lat = -1;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (b8.done) begin
                lat = c;
                break;
            end
        end
        b8.start = 1'b0;
        chk("lat8", lat, exp_lat);
        if (lat >= 0) begin
            chk("sb8_pending", sb8.size() > 0, 1'b1);
            if (sb8.size() > 0) begin
                e = sb8.pop_front();
                chk("hi8", {24'd0, b8.result_hi}, e.hi);
                chk("lo8", {24'd0, b8.result_lo}, e.lo);
                chk("dbz8", b8.div_by_zero, e.dbz);
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bit          dv;
        bit          sg;
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        b32.start = 1'b0; b32.op_div = 1'b0; b32.op_signed = 1'b0; b32.annul = 1'b0;
        b32.opa   = 32'd0; b32.opb = 32'd0;
        b8.start  = 1'b0; b8.op_div = 1'b0; b8.op_signed = 1'b0; b8.annul = 1'b0;
        b8.opa    = 8'd0; b8.opb = 8'd0;

        // Reset state.
        repeat (2) next_cycle();
        chk("rst_busy", b32.busy, 1'b0);
        chk("rst_stall", b32.stallreq, 1'b0);
        chk("rst_done", b32.done, 1'b0);
        chk("rst_dbz", b32.div_by_zero, 1'b0);
        chk("rst_hi", b32.result_hi, 32'd0);
        chk("rst_lo", b32.result_lo, 32'd0);
        rst = 1'b0;

        // Unsigned multiply of all-ones operands, start held until done.
        next_cycle();
        sb32.push_back('{1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
        start32(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done32(33, 1'b0);

        // Signed divide -7 / 2.
        next_cycle();
        sb32.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        start32(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done32(33, 1'b0);

        // Most-negative / -1 wraps.
        next_cycle();
        sb32.push_back('{1'b0, 32'h0000_0000, 32'h8000_0000});
        start32(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done32(33, 1'b0);

        // Divide by zero fast path.
        next_cycle();
        sb32.push_back('{1'b1, 32'h1234_5678, 32'hFFFF_FFFF});
        start32(1'b1, 1'b0, 32'h1234_5678, 32'd0);
        wait_done32(2, 1'b0);

        // Signed divide by zero: remainder is the raw negative dividend.
        next_cycle();
        sb32.push_back(model32(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0));
        start32(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0);
        wait_done32(2, 1'b0);

        // Ordinary multiply clears div_by_zero.
        next_cycle();
        sb32.push_back('{1'b0, 32'd0, 32'd15});
        start32(1'b0, 1'b0, 32'd3, 32'd5);
        wait_done32(33, 1'b0);

        // Annul at cycle 10 of a divide.
        next_cycle();
        start32(1'b1, 1'b0, 32'hFFFF_0000, 32'd3);
        @(negedge clk);
        b32.start = 1'b0;
        repeat (10) next_cycle();
        b32.annul = 1'b1;
        @(negedge clk);
        chk("annul_done_c10", b32.done, 1'b0);
        next_cycle();
        chk("annul_busy_c11", b32.busy, 1'b0);
        chk("annul_done_c11", b32.done, 1'b0);
        chk("annul_hold_hi", b32.result_hi, 32'd0);
        chk("annul_hold_lo", b32.result_lo, 32'd15);
        b32.annul = 1'b0;
        sb32.push_back(model32(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7));
        start32(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
        wait_done32(33, 1'b0);

        // Reset in the middle of CALC.
        next_cycle();
        start32(1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678);
        @(negedge clk);
        b32.start = 1'b0;
        repeat (5) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk("mid_rst_busy", b32.busy, 1'b0);
        chk("mid_rst_stall", b32.stallreq, 1'b0);
        chk("mid_rst_done", b32.done, 1'b0);
        chk("mid_rst_hi", b32.result_hi, 32'd0);
        chk("mid_rst_lo", b32.result_lo, 32'd0);

        // Back-to-back: multiply then divide with start held throughout.
        next_cycle();
        sb32.push_back(model32(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0010));
        start32(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0010);
        wait_done32(33, 1'b1);
        sb32.push_back(model32(1'b1, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFE));
        start32(1'b1, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFE);
        wait_done32(33, 1'b0);

        // Pseudo-random operands against the reference model.
        for (int i = 0; i < 8; i++) begin
            dv = i[0];
            sg = i[1];
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 28);
            next_cycle();
            sb32.push_back(model32(dv, sg, a, b));
            start32(dv, sg, a, b);
            wait_done32((dv && b == 32'd0) ? 2 : 33, 1'b0);
        end

        // WIDTH=8 instance.
        next_cycle();
        sb8.push_back('{1'b0, 32'h0000_0040, 32'h0000_0000});
        start8(1'b0, 1'b1, 8'h80, 8'h80);
        wait_done8(9);
        next_cycle();
        sb8.push_back('{1'b0, 32'd4, 32'd28});
        start8(1'b1, 1'b0, 8'd200, 8'd7);
        wait_done8(9);
        next_cycle();
        sb8.push_back('{1'b1, 32'h0000_0085, 32'h0000_00FF});
        start8(1'b1, 1'b1, 8'h85, 8'h00);
        wait_done8(2);

        repeat (2) next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
